// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - RV32 writeback producer: arbitrates loads and buffered ALU results onto one RF write port.
package rv32_pkg;
  typedef struct packed {
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } rv32_mem2wb_packet_t;
endpackage

// wb_alu_fifo - circular buffer for ALU results waiting behind loads.
module wb_alu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module wb_commit_stage #(
  parameter int ALU_FIFO_DEPTH = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          ld_valid,
  input  logic [4:0]                    ld_rd,
  input  logic [31:0]                   ld_rdata,
  input  logic [2:0]                    ld_funct3,
  input  logic [1:0]                    ld_addr_lo,
  output rv32_pkg::rv32_mem2wb_packet_t writeback_packet,
  output logic                          illegal_load,
  output logic [CNT_WIDTH-1:0]          retired_count
);
  localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [36:0]   fifo_head;
  logic          fifo_empty;
  logic          accept;
  logic          fifo_pop;
  logic          fifo_push;
  logic          bypass;

  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          sel_illegal;
  logic [31:0]   ld_fmt;
  logic          ld_legal;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          wen_next;

  assign alu_ready  = (fifo_count != CW'(ALU_FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign accept     = alu_valid & alu_ready;
  assign fifo_push  = accept & ~bypass & ~flush;

  wb_alu_fifo #(.DEPTH(ALU_FIFO_DEPTH), .WIDTH(37)) u_alu_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({alu_rd, alu_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign ld_byte = ld_rdata[8*ld_addr_lo +: 8];
  assign ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_fmt   = '0;
    ld_legal = 1'b1;
    case (ld_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0, ld_half};
      3'b010:  ld_fmt = ld_rdata;
      default: ld_legal = 1'b0;
    endcase
  end

  // Loads have no backpressure so they always win; flush suppresses every ALU path.
  always_comb begin
    sel_valid   = 1'b0;
    sel_rd      = writeback_packet.wb_addr;
    sel_data    = writeback_packet.wb_data;
    sel_illegal = 1'b0;
    fifo_pop    = 1'b0;
    bypass      = 1'b0;
    if (ld_valid) begin
      sel_valid   = 1'b1;
      sel_rd      = ld_rd;
      sel_data    = ld_fmt;
      sel_illegal = ~ld_legal;
    end else if (!fifo_empty && !flush) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
      sel_rd    = fifo_head[36:32];
      sel_data  = fifo_head[31:0];
    end else if (accept && !flush) begin
      sel_valid = 1'b1;
      bypass    = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
  end

  assign wen_next = sel_valid & (sel_rd != 5'd0) & ~sel_illegal;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      writeback_packet <= '0;
      illegal_load     <= 1'b0;
      retired_count    <= '0;
    end else begin
      writeback_packet.wb_enable <= wen_next;
      writeback_packet.wb_addr   <= sel_rd;
      writeback_packet.wb_data   <= sel_data;
      illegal_load               <= sel_illegal;
      if (wen_next) retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed scoreboard bench for wb_commit_stage.
module tb_wb_commit_stage;
  import rv32_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                flush;
  logic                alu_valid;
  logic                alu_ready;
  logic [4:0]          alu_rd;
  logic [31:0]         alu_data;
  logic                ld_valid;
  logic [4:0]          ld_rd;
  logic [31:0]         ld_rdata;
  logic [2:0]          ld_funct3;
  logic [1:0]          ld_addr_lo;
  rv32_mem2wb_packet_t writeback_packet;
  logic                illegal_load;
  logic [31:0]         retired_count;

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .ld_valid         (ld_valid),
    .ld_rd            (ld_rd),
    .ld_rdata         (ld_rdata),
    .ld_funct3        (ld_funct3),
    .ld_addr_lo       (ld_addr_lo),
    .writeback_packet (writeback_packet),
    .illegal_load     (illegal_load),
    .retired_count    (retired_count)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [36:0] sb[$];
  logic [36:0] alu_q[$];
  logic        exp_wen;
  logic        exp_ill;
  logic [31:0] exp_cnt;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Checks what the previous edge produced, then drives one cycle of stimulus.
  task automatic cycle(input logic lv, input logic [4:0] lrd, input logic [31:0] lrdata,
                       input logic [2:0] lf3, input logic [1:0] llo, input logic [31:0] lexp,
                       input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic fl);
    logic [36:0] item;
    logic        ready_m, legal, sel, ill, byp;
    logic [4:0]  rd;
    logic [31:0] d;
    chk("wb_enable", 32'(writeback_packet.wb_enable), 32'(exp_wen));
    if (exp_wen) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        item = sb.pop_front();
        chk("wb_addr", 32'(writeback_packet.wb_addr), 32'(item[36:32]));
        chk("wb_data", writeback_packet.wb_data, item[31:0]);
      end
    end
    chk("illegal_load", 32'(illegal_load), 32'(exp_ill));
    chk("retired_count", retired_count, exp_cnt);
    ready_m = (alu_q.size() != 4);
    chk("alu_ready", 32'(alu_ready), 32'(ready_m));

    ld_valid = lv; ld_rd = lrd; ld_rdata = lrdata; ld_funct3 = lf3; ld_addr_lo = llo;
    alu_valid = av; alu_rd = ard; alu_data = adata; flush = fl;

    last_acc = av && ready_m;
    legal = (lf3 == 3'd0) || (lf3 == 3'd1) || (lf3 == 3'd2) || (lf3 == 3'd4) || (lf3 == 3'd5);
    sel = 1'b0; ill = 1'b0; byp = 1'b0; rd = '0; d = '0;
    if (lv) begin
      sel = 1'b1; rd = lrd; d = lexp; ill = !legal;
    end else if (!fl && alu_q.size() != 0) begin
      item = alu_q.pop_front();
      sel = 1'b1; rd = item[36:32]; d = item[31:0];
    end else if (!fl && last_acc) begin
      sel = 1'b1; byp = 1'b1; rd = ard; d = adata;
    end
    exp_wen = sel && (rd != 5'd0) && !ill;
    exp_ill = ill;
    if (exp_wen) begin
      sb.push_back({rd, d});
      exp_cnt = exp_cnt + 1;
    end
    if (fl) alu_q.delete();
    else if (last_acc && !byp) alu_q.push_back({ard, adata});
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    cycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1, rd, d, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] raw, input logic [2:0] f3,
                    input logic [1:0] lo, input logic [31:0] exp);
    cycle(1'b1, rd, raw, f3, lo, exp, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int k;
    resetn = 1'b0; flush = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_rdata = '0; ld_funct3 = '0; ld_addr_lo = '0;
    exp_wen = 1'b0; exp_ill = 1'b0; exp_cnt = '0; last_acc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_packet", 32'(writeback_packet), 32'd0);
    chk("rst_illegal", 32'(illegal_load), 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_ready", 32'(alu_ready), 32'd1);
    resetn = 1'b1;

    alu(5'd5, 32'h1234);
    idle();
    chk("first_count", retired_count, 32'd1);

    cycle(1'b1, 5'd4, 32'hDEADBEEF, 3'b010, 2'd0, 32'hDEADBEEF, 1'b1, 5'd3, 32'hA, 1'b0);
    idle();
    idle();

    ld(5'd1, 32'h80FF7F01, 3'b000, 2'd1, 32'h0000007F);
    ld(5'd2, 32'h80FF7F01, 3'b000, 2'd2, 32'hFFFFFFFF);
    ld(5'd3, 32'h80FF7F01, 3'b001, 2'd2, 32'hFFFF80FF);
    ld(5'd4, 32'h80FF7F01, 3'b101, 2'd3, 32'h000080FF);
    ld(5'd5, 32'h80FF7F01, 3'b100, 2'd0, 32'h00000001);
    ld(5'd6, 32'h80FF7F01, 3'b001, 2'd1, 32'h00007F01);
    ld(5'd7, 32'h80FF7F01, 3'b010, 2'd3, 32'h80FF7F01);
    ld(5'd8, 32'h80FF7F01, 3'b011, 2'd0, 32'h0);
    idle();

    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 5'(20 + i), 32'h100 + i, 3'b010, 2'd0, 32'h100 + i,
            1'b1, 5'(10 + k), 32'h200 + k, 1'b0);
      if (last_acc) k++;
    end
    repeat (5) idle();

    alu(5'd0, 32'hFFFF);
    idle();

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(24 + i), 32'h300 + i, 3'b010, 2'd0, 32'h300 + i,
            1'b1, 5'(12 + i), 32'h400 + i, 1'b0);
    cycle(1'b1, 5'd7, 32'hCAFE0007, 3'b010, 2'd0, 32'hCAFE0007, 1'b0, 5'd0, 32'd0, 1'b1);
    idle();
    idle();
    alu(5'd9, 32'h99);
    idle();

    cycle(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1, 5'd11, 32'h11, 1'b1);
    idle();

    for (int i = 0; i < 2; i++)
      cycle(1'b1, 5'(28 + i), 32'h500 + i, 3'b010, 2'd0, 32'h500 + i,
            1'b1, 5'(16 + i), 32'h600 + i, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_packet", 32'(writeback_packet), 32'd0);
    chk("midrst_count", retired_count, 32'd0);
    chk("midrst_ready", 32'(alu_ready), 32'd1);
    chk("midrst_illegal", 32'(illegal_load), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ld_valid = 1'b0; alu_valid = 1'b0;
    sb.delete(); alu_q.delete();
    exp_wen = 1'b0; exp_ill = 1'b0; exp_cnt = '0;
    repeat (3) idle();
    alu(5'd13, 32'h1313);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
